// File: rtl/ctc_int_ctrl_if.sv
// rtl/ctc_int_ctrl_if.sv - Z80 bus, vector output and daisy-chain signals of ctc_int_ctrl
interface ctc_int_ctrl_if #(
  parameter int DWID = 8
);
  logic            m1_n;
  logic            iorq_n;
  logic            mreq_n;
  logic            rd_n;
  logic [DWID-1:0] din;
  logic            iei;
  logic [DWID-1:0] dout;
  logic            oe_n;
  logic            int_n;
  logic            ieo;

  modport master (
    output m1_n, iorq_n, mreq_n, rd_n, din, iei,
    input  dout, oe_n, int_n, ieo
  );

  modport slave (
    input  m1_n, iorq_n, mreq_n, rd_n, din, iei,
    output dout, oe_n, int_n, ieo
  );
endinterface

// File: rtl/ctc_int_ctrl.sv
// rtl/ctc_int_ctrl.sv - Z80 mode-2 interrupt controller for up to four ctc_core channels
// Option: CTC_INTC_PEND_QUEUE_EN keeps requests that arrive while the channel is in service.
module ctc_int_ctrl #(
  parameter int DWID = 8,
  parameter int NCH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  ctc_int_ctrl_if.slave    bus,
  input  logic             vec_wstb,
  input  logic [NCH-1:0]   int_req,
  input  logic [NCH-1:0]   ch_rst
);

  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_4D = 8'h4D;

  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  serv_q, serv_d;
  logic [4:0]      vec_q, vec_d;
  logic            ed_seen_q, ed_seen_d;
  logic            iack_q, fetch_q;
  logic [DWID-1:0] dout_q, dout_d;
  logic            oe_n_q, oe_n_d;
  logic            int_n_q, ieo_q;

  logic            iack1, fetch, iack_edge, fetch_edge;
  logic            ack_go, reti_go;
  logic [NCH-1:0]  ack_mask, reti_mask, req_ok;
  logic [1:0]      ack_idx;

  assign iack1      = ~bus.m1_n & ~bus.iorq_n;
  assign fetch      = ~bus.m1_n & ~bus.mreq_n & ~bus.rd_n;
  assign iack_edge  = iack1 & ~iack_q;
  assign fetch_edge = fetch & ~fetch_q;
  assign ack_go     = iack_edge & bus.iei & (|pend_q);
  assign reti_go    = fetch_edge & ed_seen_q & bus.iei & (bus.din[7:0] == OP_4D);

  // Isolate the lowest set bit: channel 0 has the highest priority.
  assign ack_mask  = pend_q & (~pend_q + NCH'(1));
  assign reti_mask = serv_q & (~serv_q + NCH'(1));

  always_comb begin
    ack_idx = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      if (ack_mask[i]) ack_idx = 2'(i);
    end
  end

  always_comb begin
    pend_d    = pend_q;
    serv_d    = serv_q;
    req_ok    = '0;
    vec_d     = vec_wstb ? bus.din[7:3] : vec_q;
    ed_seen_d = fetch_edge ? (bus.din[7:0] == OP_ED) : ed_seen_q;
    dout_d    = '0;
    oe_n_d    = 1'b1;

    if (ack_go) begin
      pend_d = pend_d & ~ack_mask;
      serv_d = serv_d | ack_mask;
    end
    if (reti_go) begin
      serv_d = serv_d & ~reti_mask;
    end

    // Requests see the in-service state after this cycle's acknowledge.
`ifdef CTC_INTC_PEND_QUEUE_EN
    req_ok = int_req;
`else
    req_ok = int_req & ~serv_d;
`endif
    pend_d = pend_d | req_ok;

    pend_d = pend_d & ~ch_rst;
    serv_d = serv_d & ~ch_rst;

    if (ack_go && ((ack_mask & ch_rst) == '0)) begin
      dout_d = DWID'({vec_q, ack_idx, 1'b0});
      oe_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q    <= '0;
      serv_q    <= '0;
      vec_q     <= '0;
      ed_seen_q <= 1'b0;
      iack_q    <= 1'b0;
      fetch_q   <= 1'b0;
      dout_q    <= '0;
      oe_n_q    <= 1'b1;
      int_n_q   <= 1'b1;
      ieo_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      serv_q    <= serv_d;
      vec_q     <= vec_d;
      ed_seen_q <= ed_seen_d;
      iack_q    <= iack1;
      fetch_q   <= fetch;
      dout_q    <= dout_d;
      oe_n_q    <= oe_n_d;
      int_n_q   <= ~(bus.iei & (|pend_q) & ~(|serv_q));
      ieo_q     <= bus.iei & ~(|pend_q) & ~(|serv_q);
    end
  end

  assign bus.dout  = dout_q;
  assign bus.oe_n  = oe_n_q;
  assign bus.int_n = int_n_q;
  assign bus.ieo   = ieo_q;

endmodule

// File: tb/tb_ctc_int_ctrl.sv
// tb/tb_ctc_int_ctrl.sv - scoreboard bench for ctc_int_ctrl
module tb_ctc_int_ctrl;
  localparam int DWID = 8;
  localparam int NCH  = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           vec_wstb = 1'b0;
  logic [NCH-1:0] int_req = '0;
  logic [NCH-1:0] ch_rst = '0;

  int             vectors = 0;
  int             errors = 0;
  logic [7:0]     exp_q[$];
  logic [7:0]     exp_v;
  logic [7:0]     vec_val;

  ctc_int_ctrl_if #(.DWID(DWID)) bus ();

  ctc_int_ctrl #(.DWID(DWID), .NCH(NCH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .vec_wstb (vec_wstb),
    .int_req  (int_req),
    .ch_rst   (ch_rst)
  );

  always #5 clk = ~clk;

  // Every cycle the vector is enabled must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.oe_n === 1'b0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vector dout=%02h oe_n=0 required oe_n=1", bus.dout);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.dout !== exp_v) begin
          errors++;
          $display("FAIL vector dout=%02h required=%02h", bus.dout, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [NCH-1:0] m);
    int_req = m;
    step();
    int_req = '0;
  endtask

  task automatic do_ack(input bit expect_vec, input logic [7:0] e);
    if (expect_vec) exp_q.push_back(e);
    bus.m1_n = 1'b0;
    bus.iorq_n = 1'b0;
    step();
    step();
    bus.m1_n = 1'b1;
    bus.iorq_n = 1'b1;
    step();
    step();
  endtask

  task automatic fetch(input logic [7:0] b);
    bus.din = b;
    bus.m1_n = 1'b0;
    bus.mreq_n = 1'b0;
    bus.rd_n = 1'b0;
    step();
    step();
    bus.m1_n = 1'b1;
    bus.mreq_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.din = 8'h00;
    step();
    step();
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  task automatic test_reset();
    repeat (3) step();
    vectors++;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%02h want=00", bus.dout); end
    vectors++;
    if (bus.oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n got=%b want=1", bus.oe_n); end
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n got=%b want=1", bus.int_n); end
    vectors++;
    if (bus.ieo !== 1'b0) begin errors++; $display("FAIL reset_ieo got=%b want=0", bus.ieo); end
    reset_n = 1'b1;
    step();
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL idle_ieo got=%b want=1", bus.ieo); end
  endtask

  task automatic test_basic();
    vec_val = 8'hA8;
    bus.din = vec_val;
    vec_wstb = 1'b1;
    step();
    vec_wstb = 1'b0;
    bus.din = 8'h00;
    pulse_req(4'b0100);
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL basic_int_n_early got=%b want=1", bus.int_n); end
    step();
    vectors++;
    if (bus.int_n !== 1'b0) begin errors++; $display("FAIL basic_int_n_low got=%b want=0", bus.int_n); end
    do_ack(1'b1, vec_val | 8'h04);
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL basic_int_n_serv got=%b want=1", bus.int_n); end
    vectors++;
    if (bus.ieo !== 1'b0) begin errors++; $display("FAIL basic_ieo_serv got=%b want=0", bus.ieo); end
    reti();
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL basic_ieo_reti got=%b want=1", bus.ieo); end
  endtask

  task automatic test_priority();
    pulse_req(4'b1010);
    step();
    vectors++;
    if (bus.int_n !== 1'b0) begin errors++; $display("FAIL prio_int_n got=%b want=0", bus.int_n); end
    do_ack(1'b1, vec_val | 8'h02);
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL prio_int_n_serv got=%b want=1", bus.int_n); end
    reti();
    vectors++;
    if (bus.int_n !== 1'b0) begin errors++; $display("FAIL prio_int_n_again got=%b want=0", bus.int_n); end
    do_ack(1'b1, vec_val | 8'h06);
    reti();
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL prio_ieo got=%b want=1", bus.ieo); end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL prio_pending_vectors got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_daisy();
    bus.iei = 1'b0;
    pulse_req(4'b0001);
    step();
    step();
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL daisy_int_n got=%b want=1", bus.int_n); end
    vectors++;
    if (bus.ieo !== 1'b0) begin errors++; $display("FAIL daisy_ieo got=%b want=0", bus.ieo); end
    do_ack(1'b0, 8'h00);
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL daisy_int_n_ack got=%b want=1", bus.int_n); end
    bus.iei = 1'b1;
    step();
    vectors++;
    if (bus.int_n !== 1'b0) begin errors++; $display("FAIL daisy_int_n_iei got=%b want=0", bus.int_n); end
    do_ack(1'b1, vec_val);
    reti();
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL daisy_ieo_end got=%b want=1", bus.ieo); end
  endtask

  task automatic test_reti_edges();
    pulse_req(4'b0001);
    step();
    do_ack(1'b1, vec_val);
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    vectors++;
    if (bus.ieo !== 1'b0) begin errors++; $display("FAIL reti_gap_ieo got=%b want=0", bus.ieo); end
    fetch(8'hED);
    bus.iei = 1'b0;
    fetch(8'h4D);
    bus.iei = 1'b1;
    step();
    step();
    vectors++;
    if (bus.ieo !== 1'b0) begin errors++; $display("FAIL reti_iei0_ieo got=%b want=0", bus.ieo); end
    reti();
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL reti_ok_ieo got=%b want=1", bus.ieo); end
  endtask

  task automatic test_ch_rst();
    ch_rst = 4'b0001;
    int_req = 4'b0001;
    step();
    ch_rst = '0;
    int_req = '0;
    step();
    step();
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL chrst_int_n got=%b want=1", bus.int_n); end
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL chrst_ieo got=%b want=1", bus.ieo); end
    pulse_req(4'b0010);
    step();
    do_ack(1'b1, vec_val | 8'h02);
    vectors++;
    if (bus.ieo !== 1'b0) begin errors++; $display("FAIL chrst_ieo_serv got=%b want=0", bus.ieo); end
    ch_rst = 4'b0010;
    step();
    ch_rst = '0;
    step();
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL chrst_ieo_clear got=%b want=1", bus.ieo); end
  endtask

  task automatic test_rerequest();
    pulse_req(4'b0001);
    step();
    do_ack(1'b1, vec_val);
    pulse_req(4'b0001);
    step();
    step();
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL rereq_int_n_serv got=%b want=1", bus.int_n); end
    reti();
`ifdef CTC_INTC_PEND_QUEUE_EN
    vectors++;
    if (bus.int_n !== 1'b0) begin errors++; $display("FAIL rereq_int_n_queued got=%b want=0", bus.int_n); end
    do_ack(1'b1, vec_val);
    reti();
`else
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL rereq_int_n_dropped got=%b want=1", bus.int_n); end
`endif
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL rereq_ieo got=%b want=1", bus.ieo); end
  endtask

  task automatic test_back_to_back();
    // Request on the same channel in the very cycle its acknowledge edge lands.
    pulse_req(4'b0100);
    step();
    exp_q.push_back(vec_val | 8'h04);
    int_req = 4'b0100;
    bus.m1_n = 1'b0;
    bus.iorq_n = 1'b0;
    step();
    int_req = '0;
    step();
    bus.m1_n = 1'b1;
    bus.iorq_n = 1'b1;
    step();
    step();
    reti();
`ifdef CTC_INTC_PEND_QUEUE_EN
    vectors++;
    if (bus.int_n !== 1'b0) begin errors++; $display("FAIL b2b_int_n_queued got=%b want=0", bus.int_n); end
    do_ack(1'b1, vec_val | 8'h04);
    reti();
`else
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL b2b_int_n_dropped got=%b want=1", bus.int_n); end
`endif
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL b2b_ieo got=%b want=1", bus.ieo); end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending_vectors got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_ack();
    pulse_req(4'b1000);
    step();
    bus.m1_n = 1'b0;
    bus.iorq_n = 1'b0;
    reset_n = 1'b0;
    step();
    vectors++;
    if (bus.oe_n !== 1'b1) begin errors++; $display("FAIL rstack_oe_n got=%b want=1", bus.oe_n); end
    bus.m1_n = 1'b1;
    bus.iorq_n = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    step();
    vectors++;
    if (bus.int_n !== 1'b1) begin errors++; $display("FAIL rstack_int_n got=%b want=1", bus.int_n); end
    vectors++;
    if (bus.ieo !== 1'b1) begin errors++; $display("FAIL rstack_ieo got=%b want=1", bus.ieo); end
  endtask

  initial begin
    bus.m1_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.mreq_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.din = 8'h00;
    bus.iei = 1'b1;
    vec_val = 8'h00;
    test_reset();
    test_basic();
    test_priority();
    test_daisy();
    test_reti_edges();
    test_ch_rst();
    test_rerequest();
    test_back_to_back();
    test_reset_mid_ack();
    step();
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending_vectors got=%0d want=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ctc_int_ctrl.md
# ctc_int_ctrl

Z80 mode-2 interrupt controller for up to four ctc_core channels. It sits directly downstream of the channels: it takes their zero-count/timeout pulses, gated by each channel's interrupt enable, and holds them as pending requests. It drives the shared `int_n` line, answers the interrupt acknowledge cycle with the channel's vector, and runs the IEI/IEO daisy chain. It tracks in-service state until RETI (ED 4D) is decoded from opcode fetches.

## Interface
- `DWID`, 8, data bus width
- `NCH`, 4, channel count (1..4); channel 0 has highest priority

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous active-low reset
- `m1_n`  in  1  Z80 M1
- `iorq_n`  in  1  Z80 IORQ
- `mreq_n`  in  1  Z80 MREQ
- `rd_n`  in  1  Z80 RD
- `din`  in  DWID  CPU data bus (vector write data, opcode sniff)
- `vec_wstb`  in  1  one-cycle strobe: `din` is the vector word
- `int_req`  in  NCH  one-cycle request pulses (channel `zc_to` AND int enable)
- `ch_rst`  in  NCH  per-channel software reset level
- `iei`  in  1  daisy-chain enable in
- `dout`  out  DWID  vector output
- `oe_n`  out  1  vector output enable, active low
- `int_n`  out  1  interrupt request, active low
- `ieo`  out  1  daisy-chain enable out

## Operation
- Per-channel state uses two independent bits, `pend` and `serv`.
- Vector register `vec[7:3]` is loaded on `vec_wstb` from `din[7:3]`. Reset value is 0.
- **Request:** `int_req[i]` sets `pend[i]`. If `pend[i]` is already 1, the request is ignored. If `serv[i]` is 1, behaviour depends on configuration.
- **Interrupt line:** `int_n` = NOT(`iei` AND any `pend` AND no `serv`), registered.
- **Daisy chain:** `ieo` = `iei` AND no `pend` AND no `serv`, registered.
- **Acknowledge:**
  - `iack1` = ~`m1_n` & ~`iorq_n`. Edge = `iack1` & ~`iack1_d`.
  - On the edge, with `iei`=1 and any `pend`, select the lowest index `k` with `pend[k]`.
  - Clear `pend[k]`, set `serv[k]`.
  - `dout` = {`vec[7:3]`, k[1:0], 1'b0}; `oe_n` = 0 for exactly one cycle.
  - Otherwise `dout`=0 and `oe_n`=1.
  - On an acknowledge with `iei`=0 or nothing pending, the block does nothing.
- **RETI decode:**
  - An opcode fetch edge is the rising edge of ~`m1_n` & ~`mreq_n` & ~`rd_n`.
  - A fetched byte 0xED sets `ed_seen`; any other fetched byte clears it.
  - A fetch of 0x4D with `ed_seen`=1 and `iei`=1 clears the lowest-index `serv` bit.
  - 0x4D with `iei`=0 leaves `serv` unchanged but still clears `ed_seen`.
- **Channel reset:** `ch_rst[i]` clears `pend[i]` and `serv[i]` every cycle it is high. It wins over a simultaneous `int_req[i]` or acknowledge.
- **Same-cycle events:**
  - Acknowledge and `int_req` on other channels: both take effect.
  - `int_req[k]` on the acknowledge edge that selects `k`: the request is treated as arriving while in service.

## Timing
- Reset values: `dout`=0, `oe_n`=1, `int_n`=1, `ieo`=0, all `pend`/`serv`=0, `ed_seen`=0, `vec`=0.
- `int_req` on edge N → `pend` set after N → `int_n` low after edge N+1 (2-cycle latency).
- Acknowledge edge detected on edge N → `dout`/`oe_n` valid during cycle N+1 → `oe_n`=1 at N+2.
- `int_n` and `ieo` update one cycle after the acknowledge or RETI state change.
- CPU strobes must be stable for at least 2 `clk` cycles (edge detect). A strobe held low produces one event only.
- Reset mid-acknowledge: all state cleared; no vector is driven.

## Configuration
- `CTC_INTC_PEND_QUEUE_EN`
- **Defined:** `int_req[i]` while `serv[i]`=1 sets `pend[i]`. After RETI the channel requests again.
- **Undefined:** `int_req[i]` while `serv[i]`=1 is dropped. `pend[i]` remains 0.

## Test plan
- **Basic vector:** `vec_wstb` with `din`=0xA8; pulse `int_req[2]`; `iei`=1; acknowledge → `int_n` low 2 cycles after the pulse; `dout`=0xAC with `oe_n`=0 for one cycle; `serv[2]`=1; `int_n`=1 and `ieo`=0.
- **Priority:** pulse `int_req[3]` and `int_req[1]` in the same cycle; acknowledge → `dout`=vec|0x02. Fetch ED then 4D → `int_n` low again. Second acknowledge → vec|0x06. Second RETI → `ieo`=1.
- **Daisy chain:** `iei`=0 with `pend[0]`=1 → `int_n`=1, `ieo`=0; acknowledge → `oe_n` stays 1. Raise `iei` → `int_n` low after 1 cycle.
- **RETI edge cases:** fetch ED, 00, 4D → `serv` unchanged. Fetch ED, 4D with `iei`=0 → unchanged. Fetch ED, 4D with `iei`=1 → cleared.
- **Channel reset collision:** `ch_rst[0]`=1 with `int_req[0]` in the same cycle → `pend[0]`=0 and `int_n` stays 1. `ch_rst[1]` while `serv[1]`=1 → `serv[1]` cleared and `ieo`=1.
- **Re-request while in service:** `int_req[0]` while `serv[0]`=1. With `CTC_INTC_PEND_QUEUE_EN`: after RETI, `int_n` goes low 1 cycle later. Without it: `int_n` stays 1.
